// File: rtl/dbg_uart_tx_arbiter.sv
// rtl/dbg_uart_tx_arbiter.sv - round-robin byte arbiter in front of the debugger UART transmitter
//
// Shares one UART transmitter between NUM_REQ byte producers. Requester 0 is
// the command-response path. Grants rotate per byte. A requester keeps the
// transmitter across a burst by holding req_last low. The block drives
// uart_din/uart_wr_en and is the only thing that does.
//
// Optional feature macro: DBG_TX_CHECKSUM_EN
//   When defined, a one-byte XOR of the burst is sent after the byte that
//   carries req_last=1. That byte gets no req_ack.
//
// Ports:
//   clk50         single clock
//   rst           synchronous active-high reset
//   req_valid     per-requester byte pending
//   req_data      byte of requester i at [8i+7:8i]
//   req_last      byte ends its burst (0 keeps the lock)
//   req_ack       one-cycle pulse, byte of requester i latched
//   grant_id      requester owning the transmitter, valid while busy
//   busy          FSM not idle, or a lock is held
//   timeout_err   sticky, uart_tx_busy never rose after a launch
//   uart_din      byte to the UART
//   uart_wr_en    one-cycle write strobe to the UART
//   uart_tx_busy  UART transmitter busy
module dbg_uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64,
    parameter int IDW          = $clog2(NUM_REQ)
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           uart_din,
    output logic                 uart_wr_en,
    input  logic                 uart_tx_busy
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } stateType;

    stateType         state;
    logic             lock;
    logic [IDW-1:0]   rrPtr;
    logic [TW-1:0]    busyTimer;

`ifdef DBG_TX_CHECKSUM_EN
    logic [7:0]       csumAcc;
    logic             csumDue;
`endif

    logic             pickValid;
    logic [IDW-1:0]   pickId;
    logic [7:0]       pickData;
    logic             pickLast;
    logic [IDW-1:0]   nextPtr;
    logic             arbGo;

    // Lowest scan offset from rrPtr wins; the loop runs downward so the
    // last assignment is the winner and no "found" flag is needed.
    always_comb begin : arbComb
        int             scanIdx;
        logic [IDW-1:0] scanId;
        pickValid = 1'b0;
        pickId    = '0;
        scanIdx   = 0;
        scanId    = '0;
        if (lock) begin
            if (req_valid[grant_id]) begin
                pickValid = 1'b1;
                pickId    = grant_id;
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scanIdx = int'(rrPtr) + k;
                if (scanIdx >= NUM_REQ) begin
                    scanIdx = scanIdx - NUM_REQ;
                end
                scanId = IDW'(scanIdx);
                if (req_valid[scanId]) begin
                    pickValid = 1'b1;
                    pickId    = scanId;
                end
            end
        end
    end

    assign pickData = req_data[{pickId, 3'b000} +: 8];
    assign pickLast = req_last[pickId];
    assign nextPtr  = (pickId == LAST_ID) ? '0 : pickId + 1'b1;
    // An externally busy transmitter blocks arbitration entirely.
    assign arbGo    = (state == IDLE) && !uart_tx_busy && pickValid;

    assign busy = (state != IDLE) || lock;

    always_ff @(posedge clk50) begin
        if (rst) begin
            state       <= IDLE;
            lock        <= 1'b0;
            rrPtr       <= '0;
            busyTimer   <= '0;
            req_ack     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            uart_din    <= 8'h00;
            uart_wr_en  <= 1'b0;
`ifdef DBG_TX_CHECKSUM_EN
            csumAcc     <= 8'h00;
            csumDue     <= 1'b0;
`endif
        end else begin
            req_ack    <= '0;
            uart_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (arbGo) begin
                        uart_din <= pickData;
                        req_ack  <= NUM_REQ'(1) << pickId;
                        grant_id <= pickId;
                        lock     <= ~pickLast;
                        // Only the first byte of a burst moves the pointer.
                        if (!lock) begin
                            rrPtr <= nextPtr;
                        end
`ifdef DBG_TX_CHECKSUM_EN
                        csumAcc <= lock ? (csumAcc ^ pickData) : pickData;
                        csumDue <= pickLast;
`endif
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    uart_wr_en <= 1'b1;
                    busyTimer  <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busyTimer == TW'(BUSY_TIMEOUT - 1)) begin
                        // Byte is dropped; the burst is abandoned with it.
                        timeout_err <= 1'b1;
                        lock        <= 1'b0;
`ifdef DBG_TX_CHECKSUM_EN
                        csumDue     <= 1'b0;
`endif
                        state       <= IDLE;
                    end else begin
                        busyTimer <= busyTimer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
`ifdef DBG_TX_CHECKSUM_EN
                        // Staying out of IDLE keeps grant/busy held while
                        // the checksum byte goes out.
                        if (csumDue) begin
                            uart_din <= csumAcc;
                            csumDue  <= 1'b0;
                            state    <= LAUNCH;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_uart_tx_arbiter.sv
// tb/tb_dbg_uart_tx_arbiter.sv - self-checking bench for dbg_uart_tx_arbiter
module tb_dbg_uart_tx_arbiter;

    localparam int NR        = 4;
    localparam int TX_CYCLES = 8;

    logic        clk50 = 1'b0;
    logic        rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy;

    logic        modelBusy;
    logic        extBusy;
    logic        modelEn;

    int tests = 0;
    int fails = 0;
    int wrCount = 0;

    logic [8:0] pendQ [NR][$];
    bit         holdReq [NR];
    logic [9:0] expQ [$];

    always #10 clk50 = ~clk50;

    assign uart_tx_busy = modelBusy | extBusy;

    dbg_uart_tx_arbiter #(
        .NUM_REQ(NR),
        .BUSY_TIMEOUT(64),
        .IDW(2)
    ) dut (
        .clk50(clk50),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ack(req_ack),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err),
        .uart_din(uart_din),
        .uart_wr_en(uart_wr_en),
        .uart_tx_busy(uart_tx_busy)
    );

    // Requester drivers: present queue head on the falling edge.
    initial begin
        logic [8:0] head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk50);
            for (int i = 0; i < NR; i++) begin
                if (!holdReq[i] && pendQ[i].size() > 0) begin
                    head = pendQ[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]        = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Ack consumer: retire acked bytes, ack must be one-hot and for a pending byte.
    initial begin
        forever begin
            @(posedge clk50);
            #1;
            if (req_ack !== '0) begin
                tests++;
                if ($countones(req_ack) != 1) begin
                    fails++;
                    $display("FAIL ack_onehot: req_ack=%b, required exactly one bit", req_ack);
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_ack[i] === 1'b1) begin
                        if (pendQ[i].size() > 0) begin
                            void'(pendQ[i].pop_front());
                        end else begin
                            fails++;
                            $display("FAIL ack_unexpected: req_ack[%0d]=1, required no ack (nothing pending)", i);
                        end
                    end
                end
            end
        end
    end

    // Strobe monitor: compare each launched byte against the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk50);
            #1;
            if (uart_wr_en === 1'b1) begin
                wrCount++;
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_unexpected: uart_din=%h grant_id=%0d, required no strobe", uart_din, grant_id);
                end else begin
                    e = expQ.pop_front();
                    if (uart_din !== e[7:0] || grant_id !== e[9:8]) begin
                        fails++;
                        $display("FAIL strobe_byte: uart_din=%h grant_id=%0d, required uart_din=%h grant_id=%0d",
                                 uart_din, grant_id, e[7:0], e[9:8]);
                    end
                end
            end
        end
    end

    // UART model: busy rises shortly after a strobe and holds TX_CYCLES edges.
    initial begin
        modelBusy = 1'b0;
        forever begin
            @(posedge clk50);
            #2;
            if (uart_wr_en === 1'b1 && modelEn) begin
                modelBusy = 1'b1;
                repeat (TX_CYCLES) @(posedge clk50);
                #2;
                modelBusy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push_req(input int id, input logic [7:0] d, input logic last);
        pendQ[id].push_back({last, d});
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        logic [1:0] idb;
        idb = id[1:0];
        expQ.push_back({idb, d});
    endtask

    task automatic exp_csum(input int id, input logic [7:0] c);
`ifdef DBG_TX_CHECKSUM_EN
        push_exp(id, c);
`else
        if (id < 0) push_exp(id, c);
`endif
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk50);
            #3;
            if (busy === 1'b0 && expQ.size() == 0 && pendQ[0].size() == 0 &&
                pendQ[1].size() == 0 && pendQ[2].size() == 0 && pendQ[3].size() == 0)
                done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: busy=%b expected_left=%0d, required idle within %0d cycles",
                     name, busy, expQ.size(), budget);
        end
    endtask

    task automatic wait_wr(input int budget, input string name);
        int w0;
        bit seen;
        w0 = wrCount;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk50);
            #3;
            if (wrCount > w0) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_strobe_wait: no uart_wr_en, required one within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk50);
        #3;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            pendQ[i].delete();
            holdReq[i] = 1'b0;
        end
        expQ.delete();
        repeat (2) @(posedge clk50);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        push_req(1, 8'hA5, 1'b1);
        repeat (3) begin
            @(posedge clk50);
            #3;
            tests++;
            if (req_ack !== 4'b0000) begin
                fails++;
                $display("FAIL ack_in_reset: req_ack=%b, required 0000", req_ack);
            end
        end
        tests++;
        if (uart_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b, required 0", uart_wr_en); end
        tests++;
        if (uart_din !== 8'h00) begin fails++; $display("FAIL reset_din: got %h, required 00", uart_din); end
        tests++;
        if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", timeout_err); end
        push_exp(1, 8'hA5);
        exp_csum(1, 8'hA5);
        rst = 1'b0;
        @(posedge clk50);
        #3;
        tests++;
        if (req_ack !== 4'b0010) begin fails++; $display("FAIL ack_after_reset: req_ack=%b, required 0010", req_ack); end
        @(posedge clk50);
        #3;
        tests++;
        if (uart_wr_en !== 1'b1) begin fails++; $display("FAIL wr_latency: uart_wr_en=%b, required 1", uart_wr_en); end
        wait_drain(100, "reset");
    endtask

    task automatic test_single();
        @(posedge clk50);
        #3;
        push_req(2, 8'h5A, 1'b1);
        push_exp(2, 8'h5A);
        exp_csum(2, 8'h5A);
        @(posedge clk50);
        #3;
        tests++;
        if (req_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: req_ack=%b, required 0100", req_ack); end
        @(posedge clk50);
        #3;
        tests++;
        if (uart_wr_en !== 1'b1 || uart_din !== 8'h5A) begin
            fails++;
            $display("FAIL single_strobe: wr_en=%b din=%h, required wr_en=1 din=5a", uart_wr_en, uart_din);
        end
        wait_drain(100, "single");
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: busy=%b, required 0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        push_req(0, 8'hA0, 1'b1);
        push_req(0, 8'hA1, 1'b1);
        push_req(3, 8'hB3, 1'b1);
        push_exp(0, 8'hA0); exp_csum(0, 8'hA0);
        push_exp(3, 8'hB3); exp_csum(3, 8'hB3);
        push_exp(0, 8'hA1); exp_csum(0, 8'hA1);
        wait_drain(200, "rr_pair");
        // pointer now 1: all four contend
        for (int i = 0; i < NR; i++) push_req(i, 8'hC0 + 8'(i), 1'b1);
        push_exp(1, 8'hC1); exp_csum(1, 8'hC1);
        push_exp(2, 8'hC2); exp_csum(2, 8'hC2);
        push_exp(3, 8'hC3); exp_csum(3, 8'hC3);
        push_exp(0, 8'hC0); exp_csum(0, 8'hC0);
        wait_drain(300, "rr_all");
    endtask

    task automatic test_lock_burst();
        bit seen;
        bit leak;
        // pointer is 1 here, so requester 1 opens the burst
        push_req(1, 8'h11, 1'b0);
        push_req(1, 8'h22, 1'b0);
        push_req(1, 8'h33, 1'b1);
        push_req(0, 8'h99, 1'b1);
        push_exp(1, 8'h11);
        push_exp(1, 8'h22);
        push_exp(1, 8'h33);
        exp_csum(1, 8'h00);
        push_exp(0, 8'h99); exp_csum(0, 8'h99);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk50);
            #3;
            if (req_ack[1] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL lock_first_ack: no req_ack[1], required within 20 cycles"); end
        holdReq[1] = 1'b1;
        leak = 1'b0;
        repeat (30) begin
            @(posedge clk50);
            #3;
            if (req_ack[0] === 1'b1 || busy !== 1'b1) leak = 1'b1;
        end
        tests++;
        if (leak) begin fails++; $display("FAIL lock_hold: req_ack[0] or busy=0 seen while locked, required lock held"); end
        holdReq[1] = 1'b0;
        wait_drain(300, "lock");
    endtask

    task automatic test_timeout();
        modelEn = 1'b0;
        push_req(2, 8'h77, 1'b0);
        push_req(3, 8'h88, 1'b1);
        push_exp(2, 8'h77);
        push_exp(3, 8'h88); exp_csum(3, 8'h88);
        wait_wr(20, "timeout");
        repeat (63) @(posedge clk50);
        #3;
        tests++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_early: timeout_err=%b, required 0 at 63 cycles", timeout_err); end
        @(posedge clk50);
        #3;
        tests++;
        if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_set: timeout_err=%b, required 1 at 64 cycles", timeout_err); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL timeout_unlock: busy=%b, required 0", busy); end
        modelEn = 1'b1;
        wait_drain(200, "timeout");
        tests++;
        if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        bit early;
        bit fell;
        push_req(0, 8'hC3, 1'b1);
        push_exp(0, 8'hC3);
        wait_wr(20, "rstmid");
        @(posedge clk50);
        #3;
        rst = 1'b1;
        push_req(1, 8'hD4, 1'b1);
        @(posedge clk50);
        #3;
        tests++;
        if (busy !== 1'b0 || uart_wr_en !== 1'b0 || timeout_err !== 1'b0 || req_ack !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_state: busy=%b wr_en=%b err=%b ack=%b, required 0 0 0 0000",
                     busy, uart_wr_en, timeout_err, req_ack);
        end
        rst = 1'b0;
        push_exp(1, 8'hD4); exp_csum(1, 8'hD4);
        early = 1'b0;
        fell = 1'b0;
        for (int c = 0; c < 30 && !fell; c++) begin
            @(posedge clk50);
            #3;
            if (req_ack !== 4'b0000) early = 1'b1;
            if (uart_tx_busy === 1'b0) fell = 1'b1;
        end
        tests++;
        if (early || !fell) begin fails++; $display("FAIL rstmid_gate: early_ack=%b busy_fell=%b, required 0 1", early, fell); end
        @(posedge clk50);
        #3;
        tests++;
        if (req_ack !== 4'b0010) begin fails++; $display("FAIL rstmid_ack: req_ack=%b, required 0010", req_ack); end
        wait_drain(100, "rstmid");
    endtask

    task automatic test_ext_busy();
        bit early;
        @(posedge clk50);
        #3;
        extBusy = 1'b1;
        push_req(0, 8'hE5, 1'b1);
        push_exp(0, 8'hE5); exp_csum(0, 8'hE5);
        early = 1'b0;
        repeat (10) begin
            @(posedge clk50);
            #3;
            if (req_ack !== 4'b0000) early = 1'b1;
        end
        tests++;
        if (early) begin fails++; $display("FAIL extbusy_hold: ack seen while uart_tx_busy=1, required none"); end
        extBusy = 1'b0;
        @(posedge clk50);
        #3;
        tests++;
        if (req_ack !== 4'b0001) begin fails++; $display("FAIL extbusy_ack: req_ack=%b, required 0001", req_ack); end
        wait_drain(100, "extbusy");
    endtask

    initial begin
        rst     = 1'b1;
        extBusy = 1'b0;
        modelEn = 1'b1;
        for (int i = 0; i < NR; i++) holdReq[i] = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_timeout();
        test_reset_mid();
        test_ext_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbg_uart_tx_arbiter.md
Name: dbg_uart_tx_arbiter

Overview:
Shares the single debugger UART transmitter between several byte producers: command responses, ROM dump, register dump and step-done acknowledge. Grants are round-robin per byte. A requester can lock the transmitter for a multi-byte burst. Sits between the producers and the uart instance, on the clk50 domain, and owns uart_din/uart_wr_en outright.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index 0 is the command-response path
BUSY_TIMEOUT, 64, clk50 cycles to wait for uart_tx_busy to rise after a launch before flagging an error
IDW, $clog2(NUM_REQ), width of grant_id

Ports:
clk50  input  1  clock; single clock for the whole block
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a byte pending
req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
req_last  input  NUM_REQ  byte of requester i ends its burst; 0 = hold lock
req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i was latched
grant_id  output  IDW  requester owning the transmitter; valid while busy=1
busy  output  1  FSM not in IDLE, or a lock is held
timeout_err  output  1  sticky; set on BUSY_TIMEOUT expiry, cleared by rst
uart_din  output  8  byte to the UART transmitter
uart_wr_en  output  1  one-cycle write strobe to the UART
uart_tx_busy  input  1  UART transmitter busy

Behaviour:
- Reset values: req_ack=0, uart_wr_en=0, uart_din=8'h00, grant_id=0, busy=0, timeout_err=0, lock=0, rr_ptr=0, FSM=IDLE.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If lock=1, arbitrate only the locked requester.
  - Otherwise pick the first requester with req_valid=1, scanning from rr_ptr upward with wrap.
  - On a pick, in the same edge: latch req_data into uart_din, pulse req_ack[i], set grant_id=i, set lock=~req_last[i], set rr_ptr=(i+1) mod NUM_REQ, go to LAUNCH.
- LAUNCH: uart_wr_en=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - When uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise count. When the count reaches BUSY_TIMEOUT: set timeout_err, clear lock, go to IDLE. The byte is dropped and not retried.
- WAIT_DONE: when uart_tx_busy=0, go to IDLE. The next byte can launch on the cycle after return to IDLE, giving a minimum 2-cycle gap between strobes.
- Latency: req_valid rising with the transmitter free gives req_ack on the next edge and uart_wr_en one cycle later.
- A requester must hold req_valid/req_data stable until req_ack. It may drop req_valid before ack (withdrawal is legal in IDLE).
- Lock:
  - While lock=1, other requesters are never acked, even if the locked requester has req_valid=0. The lock stays until a byte with req_last=1 is sent, a timeout occurs, or rst.
  - rr_ptr is not updated by locked bytes after the first byte of the burst.
- Simultaneous requests: exactly one ack per arbitration. The others stay pending and are served in round-robin order.
- uart_tx_busy already high in IDLE (external transmit): no launch until it is low. Arbitration is gated by ~uart_tx_busy.
- rst mid-operation (any state): all state returns to reset values on the next edge. A byte already acked is lost. No uart_wr_en is issued after the rst edge.
- Bytes with req_valid=1 while rst=1 are not acked.

Optional Feature:
- Macro DBG_TX_CHECKSUM_EN.
- With it: the block keeps an 8-bit XOR of every byte sent in the current burst, reset at each burst's first byte. After the byte flagged req_last=1 completes WAIT_DONE, the block inserts one extra byte equal to that XOR through LAUNCH/WAIT_BUSY/WAIT_DONE. No req_ack is issued for the checksum byte, and lock/grant is held until it completes.
- Without it: no checksum byte; the burst ends after the last byte.

Test Plan:
- req 2 sends 8'h5A with last=1, transmitter idle -> req_ack[2] on the 1st edge; uart_wr_en=1 with uart_din=8'h5A on the 2nd; busy=0 after uart_tx_busy falls.
- req 0 and req 3 both valid at once, rr_ptr=0 -> req 0 served first, then req 3; the next contention with req 0 grants req 1..3 first.
- req 1 sends burst 8'h11 (last=0), 8'h22 (last=0), 8'h33 (last=1) while req 0 is valid -> req 0 acked only after 8'h33 completes; with DBG_TX_CHECKSUM_EN, an extra byte 8'h00 is sent first.
- uart_tx_busy held 0 after launch -> after 64 cycles timeout_err=1, FSM returns to IDLE, lock cleared, next requester served.
- rst asserted during WAIT_DONE -> next edge has busy=0, uart_wr_en=0, timeout_err=0; a pending request is acked 1 cycle after rst deasserts and uart_tx_busy=0.
- uart_tx_busy=1 externally with req 0 valid -> no ack until it falls, then ack on the next edge.
